pcie_us_msi_ctrl: RTL and testbench

- MSI interrupt controller between fpga_core interrupt sources and the PCIe hard block cfg_interrupt_msi_* interface, function 0 only.
- Latches per-vector interrupt pulses into a pending register and honours the host-programmed vector count and mask.
- Issues one MSI at a time, round-robin, and waits for the hard block's sent/fail response.
- Retries on fail or timeout after a backoff.

---
 rtl/pcie_us_msi_ctrl.sv | 138 +++++++++++++
 tb/tb_pcie_us_msi_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_us_msi_ctrl.sv
// MSI interrupt controller for PCIe function 0: folds source pulses into a
// pending register and issues one masked-aware MSI at a time, round-robin, with retry.
module pcie_us_msi_ctrl #(
  parameter int MSI_COUNT    = 32,
  parameter int FAIL_BACKOFF = 16,
  parameter int WAIT_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MSI_COUNT-1:0] msi_irq,
  input  logic [3:0]           cfg_interrupt_msi_enable,
  input  logic [11:0]          cfg_interrupt_msi_mmenable,
  input  logic                 cfg_interrupt_msi_mask_update,
  input  logic [31:0]          cfg_interrupt_msi_data,
  output logic [3:0]           cfg_interrupt_msi_select,
  output logic [31:0]          cfg_interrupt_msi_int,
  output logic [31:0]          cfg_interrupt_msi_pending_status,
  output logic                 cfg_interrupt_msi_pending_status_data_enable,
  output logic [3:0]           cfg_interrupt_msi_pending_status_function_num,
  input  logic                 cfg_interrupt_msi_sent,
  input  logic                 cfg_interrupt_msi_fail,
  output logic [2:0]           cfg_interrupt_msi_attr,
  output logic                 cfg_interrupt_msi_tph_present,
  output logic [1:0]           cfg_interrupt_msi_tph_type,
  output logic [8:0]           cfg_interrupt_msi_tph_st_tag,
  output logic [3:0]           cfg_interrupt_msi_function_number,
  output logic                 busy
);

  localparam int TMAX = (WAIT_TIMEOUT > FAIL_BACKOFF) ? WAIT_TIMEOUT : FAIL_BACKOFF;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, BACKOFF} state_t;

  state_t        state;
  logic [31:0]   pending, mask, ps_q, int_q;
  logic          de_q;
  logic [4:0]    rr, sel;
  logic [TW-1:0] timer;

  logic [2:0]  la;
  logic [4:0]  amod;
  logic [31:0] amask, set_vec, clr_vec, pending_nxt, elig, rot;
  logic [63:0] dbl;
  logic [4:0]  off, pick;
  logic        found;

  always_comb begin
    la   = (cfg_interrupt_msi_mmenable[2:0] > 3'd5) ? 3'd5 : cfg_interrupt_msi_mmenable[2:0];
    amod = 5'((6'd1 << la) - 6'd1);
    amask = '0;
    for (int i = 0; i < 32; i++) amask[i] = (5'(i) <= amod);
    // Sources beyond the allocated count alias onto v mod alloc
    set_vec = '0;
    for (int v = 0; v < MSI_COUNT; v++)
      if (msi_irq[v]) set_vec[5'(v) & amod] = 1'b1;
    clr_vec = (state == WAIT && cfg_interrupt_msi_sent) ? (32'h1 << sel) : 32'h0;
    pending_nxt = ((pending & ~clr_vec) | set_vec) & amask;
  end

  // Round-robin: rotate eligible so the rr pointer lands at bit 0, take first set
  always_comb begin
    elig  = pending & ~mask & amask;
    dbl   = {elig, elig} >> rr;
    rot   = dbl[31:0];
    found = 1'b0;
    off   = '0;
    for (int i = 0; i < 32; i++)
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = 5'(i);
      end
    pick = rr + off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      mask    <= '0;
      ps_q    <= '0;
      de_q    <= 1'b0;
      int_q   <= '0;
      rr      <= '0;
      sel     <= '0;
      timer   <= '0;
    end else begin
      pending <= pending_nxt;
      ps_q    <= pending;
      de_q    <= (pending != ps_q);
      int_q   <= '0;
      if (cfg_interrupt_msi_mask_update) mask <= cfg_interrupt_msi_data;
      case (state)
        IDLE: if (cfg_interrupt_msi_enable[0] && found) begin
          sel   <= pick;
          int_q <= 32'h1 << pick;
          state <= ISSUE;
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (cfg_interrupt_msi_sent) begin
            rr    <= 5'(sel + 5'd1) & amod;
            state <= IDLE;
          end else if (cfg_interrupt_msi_fail || timer == TW'(WAIT_TIMEOUT - 1)) begin
            timer <= '0;
            state <= BACKOFF;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        BACKOFF: begin
          if (timer == TW'(FAIL_BACKOFF - 1)) state <= IDLE;
          else timer <= timer + TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cfg_interrupt_msi_int                         = int_q;
  assign cfg_interrupt_msi_pending_status              = ps_q;
  assign cfg_interrupt_msi_pending_status_data_enable  = de_q;
  assign busy                                          = (state != IDLE);
  assign cfg_interrupt_msi_select                      = 4'd0;
  assign cfg_interrupt_msi_pending_status_function_num = 4'd0;
  assign cfg_interrupt_msi_attr                        = 3'd0;
  assign cfg_interrupt_msi_tph_present                 = 1'b0;
  assign cfg_interrupt_msi_tph_type                    = 2'd0;
  assign cfg_interrupt_msi_tph_st_tag                  = 9'd0;
  assign cfg_interrupt_msi_function_number             = 4'd0;

  logic unused_ok;
  assign unused_ok = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

endmodule

// File: tb/tb_pcie_us_msi_ctrl.sv
// Scoreboard bench for pcie_us_msi_ctrl: stimulus pushes expected MSI issues and
// pending_status images; a negedge monitor pops and compares them.
module tb_pcie_us_msi_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] msi_irq = '0;
  logic [3:0]  msi_enable = '0;
  logic [11:0] mmenable = '0;
  logic        mask_update = 1'b0;
  logic [31:0] msi_data = '0;
  logic [3:0]  msi_select;
  logic [31:0] msi_int;
  logic [31:0] pstat;
  logic        pstat_de;
  logic [3:0]  pstat_fn;
  logic        sent = 1'b0;
  logic        fail = 1'b0;
  logic [2:0]  attr;
  logic        tph_present;
  logic [1:0]  tph_type;
  logic [8:0]  tph_st_tag;
  logic [3:0]  fn_num;
  logic        busy;

  pcie_us_msi_ctrl dut (
    .clk(clk), .rst_n(rst_n), .msi_irq(msi_irq),
    .cfg_interrupt_msi_enable(msi_enable),
    .cfg_interrupt_msi_mmenable(mmenable),
    .cfg_interrupt_msi_mask_update(mask_update),
    .cfg_interrupt_msi_data(msi_data),
    .cfg_interrupt_msi_select(msi_select),
    .cfg_interrupt_msi_int(msi_int),
    .cfg_interrupt_msi_pending_status(pstat),
    .cfg_interrupt_msi_pending_status_data_enable(pstat_de),
    .cfg_interrupt_msi_pending_status_function_num(pstat_fn),
    .cfg_interrupt_msi_sent(sent),
    .cfg_interrupt_msi_fail(fail),
    .cfg_interrupt_msi_attr(attr),
    .cfg_interrupt_msi_tph_present(tph_present),
    .cfg_interrupt_msi_tph_type(tph_type),
    .cfg_interrupt_msi_tph_st_tag(tph_st_tag),
    .cfg_interrupt_msi_function_number(fn_num),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_int[$];
  logic [31:0] exp_ps[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every issue pulse and every pending_status strobe must match the next expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (msi_int != 32'h0) begin
        checks++;
        if (exp_int.size() == 0) begin
          errors++;
          $display("FAIL int_unexpected: got %08h at cycle %0d, none expected", msi_int, cyc);
        end else begin
          logic [31:0] e;
          e = exp_int.pop_front();
          if (msi_int !== e) begin
            errors++;
            $display("FAIL int_value: got %08h expected %08h at cycle %0d", msi_int, e, cyc);
          end
        end
      end
      if (pstat_de) begin
        checks++;
        if (exp_ps.size() == 0) begin
          errors++;
          $display("FAIL pstat_unexpected: got %08h at cycle %0d, none expected", pstat, cyc);
        end else begin
          logic [31:0] e;
          e = exp_ps.pop_front();
          if (pstat !== e) begin
            errors++;
            $display("FAIL pstat_value: got %08h expected %08h at cycle %0d", pstat, e, cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [31:0] v, output int c);
    msi_irq = v;
    c = cyc;
    tick();
    msi_irq = '0;
  endtask

  task automatic set_mask(input logic [31:0] m);
    mask_update = 1'b1;
    msi_data = m;
    tick();
    mask_update = 1'b0;
    msi_data = '0;
  endtask

  // Returns at the negedge where an issue pulse is visible
  task automatic wait_issue(input int budget, input string name, output int c);
    int n = 0;
    @(negedge clk);
    while (msi_int == 32'h0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    c = cyc;
    if (msi_int == 32'h0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no issue within %0d cycles", name, budget);
    end
  endtask

  task automatic respond(input logic is_fail);
    tick();
    if (is_fail) fail = 1'b1; else sent = 1'b1;
    tick();
    sent = 1'b0;
    fail = 1'b0;
  endtask

  task automatic do_reset();
    repeat (4) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int p, c, c2;
    repeat (2) tick();
    // Reset state
    check("rst_int", msi_int, 32'h0);
    check("rst_pstat", pstat, 32'h0);
    check("rst_de_busy", {30'h0, pstat_de, busy}, 32'h0);
    check("const_outs", {8'h0, msi_select, pstat_fn, attr, tph_present, tph_type, tph_st_tag, fn_num}, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: single vector, latency N+2, status image set then cleared
    msi_enable = 4'h1;
    mmenable = 12'd3;
    repeat (3) tick();
    exp_int.push_back(32'h8);
    exp_ps.push_back(32'h8);
    exp_ps.push_back(32'h0);
    pulse(32'h8, p);
    wait_issue(20, "t1", c);
    check("t1_latency", c - p, 32'd2);
    @(negedge clk);
    check("t1_one_cycle", msi_int, 32'h0);
    check("t1_busy", {31'h0, busy}, 32'h1);
    respond(1'b0);
    do_reset();

    // 2: four vectors, irq[10] folds onto vector 2
    mmenable = 12'd2;
    exp_int.push_back(32'h4);
    exp_ps.push_back(32'h4);
    exp_ps.push_back(32'h0);
    pulse(32'h400, p);
    wait_issue(20, "t2", c);
    respond(1'b0);
    do_reset();

    // 3: round robin with wrap
    mmenable = 12'd3;
    exp_int.push_back(32'h02); exp_int.push_back(32'h20);
    exp_int.push_back(32'h02); exp_int.push_back(32'h20);
    exp_ps.push_back(32'h22); exp_ps.push_back(32'h20); exp_ps.push_back(32'h00);
    exp_ps.push_back(32'h22); exp_ps.push_back(32'h20); exp_ps.push_back(32'h00);
    for (int k = 0; k < 2; k++) begin
      pulse(32'h22, p);
      wait_issue(20, "t3a", c);
      respond(1'b0);
      wait_issue(20, "t3b", c);
      respond(1'b0);
      repeat (4) tick();
    end
    do_reset();

    // 4: fail then backoff then reissue
    exp_int.push_back(32'h1);
    exp_int.push_back(32'h1);
    exp_ps.push_back(32'h1);
    exp_ps.push_back(32'h0);
    pulse(32'h1, p);
    wait_issue(20, "t4a", c);
    respond(1'b1);
    repeat (3) tick();
    check("t4_busy_backoff", {31'h0, busy}, 32'h1);
    wait_issue(40, "t4b", c2);
    check("t4_reissue_gap", c2 - c, 32'd19);
    respond(1'b0);
    do_reset();

    // 5: masked vector stays pending, issues after unmask
    set_mask(32'h1);
    exp_ps.push_back(32'h1);
    pulse(32'h1, p);
    repeat (10) tick();
    check("t5_masked_pstat", pstat, 32'h1);
    check("t5_masked_busy", {31'h0, busy}, 32'h0);
    exp_int.push_back(32'h1);
    exp_ps.push_back(32'h0);
    set_mask(32'h0);
    wait_issue(20, "t5", c);
    respond(1'b0);
    do_reset();

    // 6: disabled, then enabled, timeout retry, reset mid-WAIT
    msi_enable = 4'h0;
    exp_ps.push_back(32'h4);
    pulse(32'h4, p);
    repeat (10) tick();
    check("t6_disabled_busy", {31'h0, busy}, 32'h0);
    check("t6_disabled_pstat", pstat, 32'h4);
    exp_int.push_back(32'h4);
    exp_int.push_back(32'h4);
    msi_enable = 4'h1;
    wait_issue(20, "t6a", c);
    wait_issue(1100, "t6b", c2);
    check("t6_timeout_gap", c2 - c, 32'd1042);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_int", msi_int, 32'h0);
    check("t6_rst_pstat", pstat, 32'h0);
    check("t6_rst_de_busy", {30'h0, pstat_de, busy}, 32'h0);
    tick();
    rst_n = 1'b1;
    sent = 1'b1;
    tick();
    sent = 1'b0;
    repeat (10) tick();
    check("t6_post_rst_busy", {31'h0, busy}, 32'h0);
    check("t6_post_rst_pstat", pstat, 32'h0);

    check("int_queue_drained", exp_int.size(), 32'h0);
    check("ps_queue_drained", exp_ps.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
